// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, divider state encoding and the div funct decode.
package cpu_pkg;
  localparam int WORD_W = 32;

  localparam logic [5:0] FUNCT_DIV = 6'h1A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the control FSM and div_unit.
interface div_unit_if;
  import cpu_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a_in;
  logic [WORD_W-1:0] b_in;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [WORD_W-1:0] hi_out;
  logic [WORD_W-1:0] lo_out;

  modport master (output start, a_in, b_in,
                  input  busy, done, div_zero, hi_out, lo_out);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/div_unit.sv
// Iterative signed divider for MIPS div: radix-2 restoring, one quotient bit per clock.
// Quotient goes to LO, remainder to HI; done/div_zero are single-cycle pulses.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_b_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_b_zero = (bus.b_in == '0);

  // Remainder stays below |b| <= 2^31, so the 33-bit trial never wraps and its MSB is the borrow.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = w_b_zero ? DONE : CALC;
      CALC: if (r_cnt == 5'd0) w_state_nxt = SIGN;
      SIGN: w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dz <= w_b_zero;
            if (!w_b_zero) begin
              r_dvd    <= bus.a_in[WIDTH-1] ? neg(bus.a_in) : bus.a_in;
              r_dvs    <= bus.b_in[WIDTH-1] ? neg(bus.b_in) : bus.b_in;
              r_sign_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
              r_sign_r <= bus.a_in[WIDTH-1];
              r_rem    <= '0;
              r_quo    <= '0;
              r_cnt    <= 5'd31;
            end
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        SIGN: begin
          // 0x80000000 / -1 wraps naturally back to 0x80000000, matching MIPS (no trap).
          r_lo <= r_sign_q ? neg(r_quo) : r_quo;
          r_hi <= r_sign_r ? neg(r_rem) : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.div_zero = (r_state == DONE) && r_dz;
  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;

endmodule
